// File: rtl/trng_pkg.sv
// trng_pkg: shared types and constants for the TRNG conditioner.
//   debias_state_t : von Neumann debias FSM states
//   LFSR_TAPS/SEED : Galois whitening LFSR constants (used only when
//                    TRNG_LFSR_WHITEN_EN is defined)
//   RC_W           : width of the saturating repetition counter
package trng_pkg;

    typedef enum logic {
        PAIR_A = 1'b0,   // waiting for / holding the first bit of a pair
        PAIR_B = 1'b1    // comparing the second bit against the held one
    } debias_state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_ACE1;
    localparam int          RC_W      = 8;

endpackage

// File: rtl/trng_fifo.sv
// trng_fifo: small show-ahead FIFO holding conditioned words.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push, wdata   : write request and data (ignored when full unless a pop
//                   happens in the same cycle)
//   pop           : read request (ignored when empty)
//   rdata         : head word, forced to 0 while empty
//   full, empty   : occupancy flags
//   level         : number of words held, 0..DEPTH
module trng_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_pop;
    logic             do_push;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when a word leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign level   = level_reg;
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/trng_conditioner.sv
// trng_conditioner: von Neumann debiaser, word assembler, repetition-count
// health test and output FIFO for a raw entropy bit stream.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : conditioning enable (raw samples ignored when low)
//   raw_bit, raw_valid  : raw entropy sample and its qualifier
//   out_data, out_valid : FIFO head word and non-empty flag
//   out_ready           : consumer accept; pops when out_valid is high
//   fifo_level          : words currently buffered
//   health_fail         : sticky repetition-count failure
//   fault_clr           : pulse clearing health_fail and the repetition count
//   ovf                 : one-cycle pulse when a finished word is dropped
// Optional feature: define TRNG_LFSR_WHITEN_EN to XOR each finished word with
// a 32-bit Galois LFSR before it enters the FIFO.
module trng_conditioner #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int RC_CUTOFF = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     raw_bit,
    input  logic                     raw_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     health_fail,
    input  logic                     fault_clr,
    output logic                     ovf
);
    import trng_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    debias_state_t    state_reg, state_next;
    logic             first_reg, first_next;
    logic [WIDTH-1:0] asm_reg, asm_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             push_reg, push_next;
    logic [RC_W-1:0]  rc_reg, rc_next;
    logic             last_reg, last_next;
    logic             health_reg, health_next;
    logic             ovf_reg;

    logic             sample;
    logic             deb_valid;
    logic             deb_bit;
    logic             rc_hit;
    logic             push_en;
    logic [WIDTH-1:0] push_data;
    logic             fifo_full;
    logic             fifo_empty;

    assign sample  = en && raw_valid;
    // A word completed just before a health failure is discarded too.
    assign push_en = push_reg && !health_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= PAIR_A;
            first_reg  <= 1'b0;
            asm_reg    <= '0;
            cnt_reg    <= '0;
            word_reg   <= '0;
            push_reg   <= 1'b0;
            rc_reg     <= '0;
            last_reg   <= 1'b0;
            health_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            first_reg  <= first_next;
            asm_reg    <= asm_next;
            cnt_reg    <= cnt_next;
            word_reg   <= word_next;
            push_reg   <= push_next;
            rc_reg     <= rc_next;
            last_reg   <= last_next;
            health_reg <= health_next;
            // Full with no pop in the same cycle means the word is lost.
            ovf_reg    <= push_en && fifo_full && !out_ready;
        end
    end

    always_comb begin
        state_next  = state_reg;
        first_next  = first_reg;
        asm_next    = asm_reg;
        cnt_next    = cnt_reg;
        word_next   = word_reg;
        push_next   = 1'b0;
        rc_next     = rc_reg;
        last_next   = last_reg;
        health_next = health_reg;
        deb_valid   = 1'b0;
        deb_bit     = 1'b0;
        rc_hit      = 1'b0;

        if (sample) begin
            // rc_reg == 0 means no run in progress (after reset or fault_clr).
            if (rc_reg == '0 || raw_bit != last_reg) begin
                rc_next = RC_W'(1);
            end else if (rc_reg != '1) begin
                rc_next = rc_reg + 1'b1;
            end
            last_next = raw_bit;
            rc_hit    = (rc_next == RC_W'(RC_CUTOFF));

            case (state_reg)
                PAIR_A: begin
                    first_next = raw_bit;
                    state_next = PAIR_B;
                end
                PAIR_B: begin
                    state_next = PAIR_A;
                    // 10 -> 1, 01 -> 0: the debiased bit is the first bit.
                    if (first_reg != raw_bit) begin
                        deb_valid = 1'b1;
                        deb_bit   = first_reg;
                    end
                end
                default: state_next = PAIR_A;
            endcase
        end

        // Shift in at the MSB so the first bit ends up at bit 0.
        if (deb_valid) begin
            asm_next = {deb_bit, asm_reg[WIDTH-1:1]};
            if (cnt_reg == CNT_W'(WIDTH-1)) begin
                cnt_next  = '0;
                word_next = asm_next;
                push_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        if (health_reg) begin
            state_next = PAIR_A;
            first_next = 1'b0;
            asm_next   = '0;
            cnt_next   = '0;
            push_next  = 1'b0;
        end

        if (fault_clr && !rc_hit) begin
            health_next = 1'b0;
            rc_next     = '0;
        end
        if (rc_hit) begin
            health_next = 1'b1;
        end
    end

`ifdef TRNG_LFSR_WHITEN_EN
    logic [31:0] lfsr_reg;

    // The LFSR steps once for every word offered to the FIFO, dropped or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else if (push_en) begin
            lfsr_reg <= {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 32'd0);
        end
    end

    assign push_data = word_reg ^ lfsr_reg[WIDTH-1:0];
`else
    assign push_data = word_reg;
`endif

    trng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en),
        .wdata (push_data),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign out_valid   = !fifo_empty;
    assign health_fail = health_reg;
    assign ovf         = ovf_reg;

endmodule

// File: tb/tb_trng_conditioner.sv
// tb_trng_conditioner: directed self-checking bench for trng_conditioner
// (WIDTH=8, DEPTH=4, RC_CUTOFF=16). Inputs change and outputs are sampled on
// the falling clock edge. Build with TRNG_LFSR_WHITEN_EN to check whitening.
module tb_trng_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       raw_bit;
    logic       raw_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_level;
    logic       health_fail;
    logic       fault_clr;
    logic       ovf;

    int n_pass  = 0;
    int n_total = 0;
    int ovf_cnt = 0;
    int ovf_base;

    logic [7:0] e [6];
    logic [7:0] e_single;

`ifdef TRNG_LFSR_WHITEN_EN
    logic [31:0] lfsr_m;
`endif

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ovf === 1'b1) ovf_cnt++;
    end

    trng_conditioner #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RC_CUTOFF (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level),
        .health_fail (health_fail),
        .fault_clr   (fault_clr),
        .ovf         (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected FIFO word for the next word offered to the FIFO.
    task automatic expect_word(input logic [7:0] w, output logic [7:0] x);
`ifdef TRNG_LFSR_WHITEN_EN
        x = w ^ lfsr_m[7:0];
        lfsr_m = {1'b0, lfsr_m[31:1]} ^ (lfsr_m[0] ? 32'h8020_0003 : 32'h0);
`else
        x = w;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef TRNG_LFSR_WHITEN_EN
        lfsr_m = 32'h0000_ACE1;
`endif
    endtask

    task automatic sample(input logic b);
        raw_valid = 1'b1;
        raw_bit   = b;
        @(negedge clk);
        raw_valid = 1'b0;
    endtask

    task automatic send_pair(input logic a, input logic b);
        sample(a);
        sample(b);
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            if (w[i]) send_pair(1'b1, 1'b0);
            else      send_pair(1'b0, 1'b1);
        end
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        raw_bit   = 1'b0;
        raw_valid = 1'b0;
        out_ready = 1'b0;
        fault_clr = 1'b0;
        repeat (2) @(negedge clk);

        // ---- reset state ----
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_health", 32'(health_fail), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        do_reset();

        // ---- basic word: bits 1,0,1,1,0,0,1,0 LSB-first = 0x4D ----
        send_pair(1, 0); send_pair(0, 1); send_pair(1, 0); send_pair(1, 0);
        send_pair(0, 1); send_pair(0, 1); send_pair(1, 0); send_pair(0, 1);
        expect_word(8'h4D, e_single);
        chk("lat1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat2_out_valid", 32'(out_valid), 32'd1);
        chk("basic_word", 32'(out_data), 32'(e_single));
        chk("basic_level", 32'(fifo_level), 32'd1);
        pop_one();
        chk("pop_empty_valid", 32'(out_valid), 32'd0);
        pop_one();
        chk("pop_empty_level", 32'(fifo_level), 32'd0);
        chk("pop_empty_data", 32'(out_data), 32'd0);

        // ---- 00/11 pairs ignored, en low mid-pair; bits 1,1,0,1,0,0,1,1 = 0xCB ----
        send_pair(1, 0); send_pair(0, 0); send_pair(1, 0); send_pair(1, 1);
        send_pair(0, 1);
        sample(1);
        en        = 1'b0;
        raw_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            raw_bit = ~raw_bit;
            @(negedge clk);
        end
        raw_valid = 1'b0;
        en        = 1'b1;
        sample(0);
        send_pair(0, 0); send_pair(0, 1); send_pair(0, 1); send_pair(1, 1);
        send_pair(1, 0);
        repeat (3) @(negedge clk);
        chk("seven_bits_level", 32'(fifo_level), 32'd0);
        send_pair(1, 0);
        expect_word(8'hCB, e_single);
        @(negedge clk);
        chk("filter_valid", 32'(out_valid), 32'd1);
        chk("filter_word", 32'(out_data), 32'(e_single));
        pop_one();

        // ---- overflow: five words into DEPTH=4 ----
        do_reset();
        ovf_base = ovf_cnt;
        for (int i = 0; i < 4; i++) begin
            send_word(8'(8'h11 * (i + 1)));
            expect_word(8'(8'h11 * (i + 1)), e[i]);
        end
        repeat (2) @(negedge clk);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);
        send_word(8'h55);
        expect_word(8'h55, e[4]);
        repeat (2) @(negedge clk);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_pulses", 32'(ovf_cnt - ovf_base), 32'd1);
        chk("ovf_head", 32'(out_data), 32'(e[0]));
        // push and pop in the same cycle while full
        send_word(8'h66);
        expect_word(8'h66, e[5]);
        pop_one();
        chk("pushpop_level", 32'(fifo_level), 32'd4);
        chk("pushpop_head", 32'(out_data), 32'(e[1]));
        @(negedge clk);
        chk("pushpop_no_ovf", 32'(ovf_cnt - ovf_base), 32'd1);
        chk("drain0", 32'(out_data), 32'(e[1])); pop_one();
        chk("drain1", 32'(out_data), 32'(e[2])); pop_one();
        chk("drain2", 32'(out_data), 32'(e[3])); pop_one();
        chk("drain3", 32'(out_data), 32'(e[5])); pop_one();
        chk("drained_level", 32'(fifo_level), 32'd0);

        // ---- repetition-count health test ----
        do_reset();
        for (int i = 0; i < 15; i++) sample(1);
        chk("rc15_health", 32'(health_fail), 32'd0);
        sample(1);
        chk("rc16_health", 32'(health_fail), 32'd1);
        send_word(8'hA5);
        repeat (2) @(negedge clk);
        chk("fail_no_push", 32'(fifo_level), 32'd0);
        chk("fail_sticky", 32'(health_fail), 32'd1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_health", 32'(health_fail), 32'd0);
        // a cutoff hit in the same cycle as fault_clr wins
        for (int i = 0; i < 15; i++) sample(1);
        raw_valid = 1'b1;
        raw_bit   = 1'b1;
        fault_clr = 1'b1;
        @(negedge clk);
        raw_valid = 1'b0;
        fault_clr = 1'b0;
        chk("set_priority", 32'(health_fail), 32'd1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_again", 32'(health_fail), 32'd0);
        send_word(8'h5A);
        expect_word(8'h5A, e_single);
        @(negedge clk);
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_word", 32'(out_data), 32'(e_single));

        // ---- reset mid-word ----
        do_reset();
        ovf_base = ovf_cnt;
        send_pair(1, 0); send_pair(1, 0); send_pair(1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_health", 32'(health_fail), 32'd0);
        rst = 1'b0;
`ifdef TRNG_LFSR_WHITEN_EN
        lfsr_m = 32'h0000_ACE1;
`endif
        send_word(8'h3C);
        expect_word(8'h3C, e_single);
        @(negedge clk);
        chk("fresh_word", 32'(out_data), 32'(e_single));
        chk("fresh_level", 32'(fifo_level), 32'd1);
        chk("midrst_no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
